// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide coprocessor holding HI/LO
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               a_neg_q, a_neg_d;
    logic               b_zero_q, b_zero_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               in_sgn, in_a_neg, in_b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_trial;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        in_sgn   = ~op[0];
        in_a_neg = in_sgn & a[WIDTH-1];
        in_b_neg = in_sgn & b[WIDTH-1];
        a_mag    = in_a_neg ? -a : a;
        b_mag    = in_b_neg ? -b : b;

        // acc holds {partial, multiplier} for multiply and {remainder, quotient} for divide
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        div_ok    = ~div_trial[WIDTH];
        div_next  = {(div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ok};

        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        a_neg_d  = a_neg_q;
        b_zero_d = b_zero_q;
        a_d      = a_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d = op[1];
                    neg_d    = in_a_neg ^ in_b_neg;
                    a_neg_d  = in_a_neg;
                    b_zero_d = (b == '0);
                    a_d      = a;
                    opnd_d   = op[1] ? b_mag : a_mag;
                    acc_d    = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end else begin
                    if (wr_hi) hi_d = wd;
                    if (wr_lo) lo_d = wd;
                end
            end
            CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) state_d = FINISH;
            end
            FINISH: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (b_zero_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            a_q      <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            a_neg_q  <= a_neg_d;
            b_zero_q <= b_zero_d;
            a_q      <= a_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        wr_hi, wr_lo;
    logic [31:0] wd;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks;
    int errors;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic on the architectural definition
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] r;
        longint sx, sy, q, m;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: r = 64'(sx * sy);
            2'b01: r = {32'b0, x} * {32'b0, y};
            2'b10: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    m = sx % sy;
                    r = {m[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else r = {x % y, x / y};
            end
        endcase
        return r;
    endfunction

    // Called at posedge+1; issues start, returns edges from start edge to done (0 on timeout)
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
        end
    endtask

    task automatic test_multu_max();
        int busy_bad, lat;
        busy_bad = 0;
        lat = 0;
        start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n <= 32; n++) begin
            if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
            @(posedge clk); #1;
        end
        if (done === 1'b1) lat = 33;
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL multu_busy_window: %0d cycles wrong, want 0", busy_bad);
        end
        checks++;
        if (lat != 33 || busy !== 1'b0) begin
            errors++;
            $display("FAIL multu_done_latency: done=%b busy=%b at edge 33, want 1 0", done, busy);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu_max_result: hi=%h lo=%h, want fffffffe 00000001", hi, lo);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_single_pulse: done=%b, want 0", done);
        end
    endtask

    task automatic test_directed();
        logic [31:0] to [5];
        logic [31:0] ta [5];
        logic [31:0] tb [5];
        logic [63:0] want [5];
        int lat;
        to[0] = 32'd0; ta[0] = 32'hFFFF_FFFD; tb[0] = 32'h5; want[0] = 64'hFFFF_FFFF_FFFF_FFF1;
        to[1] = 32'd2; ta[1] = 32'hFFFF_FFF9; tb[1] = 32'h2; want[1] = 64'hFFFF_FFFF_FFFF_FFFD;
        to[2] = 32'd2; ta[2] = 32'h8000_0000; tb[2] = 32'hFFFF_FFFF; want[2] = 64'h0000_0000_8000_0000;
        to[3] = 32'd3; ta[3] = 32'h0000_000A; tb[3] = 32'h0; want[3] = 64'h0000_000A_FFFF_FFFF;
        to[4] = 32'd2; ta[4] = 32'hFFFF_FFF0; tb[4] = 32'h0; want[4] = 64'hFFFF_FFF0_FFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            do_op(to[i][1:0], ta[i], tb[i], lat);
            checks++;
            if (lat != 33 || {hi, lo} !== want[i]) begin
                errors++;
                $display("FAIL directed_%0d: lat=%0d hi=%h lo=%h, want lat=33 %h", i, lat, hi, lo, want[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL directed_%0d_done_pulse: done=%b, want 0", i, done);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int lat;
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7; wr_hi = 1'b1; wd = 32'h55;
        @(posedge clk); #1;
        start = 1'b0; wr_hi = 1'b0;
        lat = 0;
        for (int n = 6; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
        end
        checks++;
        if (lat != 33 || hi !== 32'h0 || lo !== 32'h0000_000C) begin
            errors++;
            $display("FAIL ignore_while_busy: lat=%0d hi=%h lo=%h, want 33 00000000 0000000c", lat, hi, lo);
        end
        wr_hi = 1'b1; wd = 32'h55;
        @(posedge clk); #1;
        wr_hi = 1'b0;
        checks++;
        if (hi !== 32'h55 || lo !== 32'h0000_000C) begin
            errors++;
            $display("FAIL mthi_idle: hi=%h lo=%h, want 00000055 0000000c", hi, lo);
        end
    endtask

    task automatic test_mtlo_both_and_priority();
        int lat;
        wr_lo = 1'b1; wd = 32'hA5A5_0001;
        @(posedge clk); #1;
        wr_lo = 1'b0;
        checks++;
        if (hi !== 32'h55 || lo !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL mtlo_idle: hi=%h lo=%h, want 00000055 a5a50001", hi, lo);
        end
        wr_hi = 1'b1; wr_lo = 1'b1; wd = 32'h1234_5678;
        @(posedge clk); #1;
        wr_hi = 1'b0; wr_lo = 1'b0;
        checks++;
        if (hi !== 32'h1234_5678 || lo !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mthi_mtlo_both: hi=%h lo=%h, want 12345678 12345678", hi, lo);
        end
        start = 1'b1; op = 2'b01; a = 32'd7; b = 32'd6; wr_hi = 1'b1; wr_lo = 1'b1; wd = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        checks++;
        if (busy !== 1'b1 || hi !== 32'h1234_5678 || lo !== 32'h1234_5678) begin
            errors++;
            $display("FAIL start_priority: busy=%b hi=%h lo=%h, want 1 12345678 12345678", busy, hi, lo);
        end
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
        end
        checks++;
        if (lat != 33 || hi !== 32'h0 || lo !== 32'd42) begin
            errors++;
            $display("FAIL start_priority_result: lat=%0d hi=%h lo=%h, want 33 0 0000002a", lat, hi, lo);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        start = 1'b1; op = 2'b00; a = 32'hFFFF_FF00; b = 32'h0000_0123;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        do_op(2'b01, 32'd2, 32'd3, lat);
        checks++;
        if (lat != 33 || hi !== 32'h0 || lo !== 32'd6) begin
            errors++;
            $display("FAIL after_reset_multu: lat=%0d hi=%h lo=%h, want 33 0 00000006", lat, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x, y;
        logic [63:0] want;
        int lat;
        x = 32'hFFFF_FFEC; y = 32'd6;
        want = model(2'b10, x, y);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_entry: done=%b busy=%b, want 1 0", done, busy);
        end
        do_op(2'b10, x, y, lat);
        checks++;
        if (lat != 33 || {hi, lo} !== want) begin
            errors++;
            $display("FAIL b2b_div: lat=%0d hi=%h lo=%h, want 33 %h", lat, hi, lo, want);
        end
    endtask

    task automatic test_random();
        logic [31:0] corner [6];
        logic [31:0] x, y;
        logic [1:0]  o;
        logic [63:0] want;
        int lat;
        corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF; corner[5] = 32'h0000_0002;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] :
                (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 1000)));
            want = model(o, x, y);
            do_op(o, x, y, lat);
            checks++;
            if (lat != 33 || {hi, lo} !== want) begin
                errors++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: lat=%0d hi=%h lo=%h, want 33 %h",
                         i, o, x, y, lat, hi, lo, want);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        start = 1'b0; op = 2'b00; a = '0; b = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wd = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_multu_max();
        test_directed();
        test_ignore_busy();
        test_mtlo_both_and_priority();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide coprocessor holding the architectural HI/LO registers. It sits downstream of the single-cycle core's register file: it consumes the RD1/RD2 operands of mult/multu/div/divu and mthi/mtlo. It returns HI/LO for mfhi/mflo, with a busy/done handshake the controller uses to stall the PC. One result is produced per operation, after a fixed multi-cycle latency.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH bits each, product/dividend path is 2*WIDTH. Only 32 is verified.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  launch operation; sampled only when busy=0
op  input  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu
a  input  WIDTH  rs operand (multiplicand / dividend)
b  input  WIDTH  rt operand (multiplier / divisor)
wr_hi  input  1  mthi strobe: hi <= wd
wr_lo  input  1  mtlo strobe: lo <= wd
wd  input  WIDTH  mthi/mtlo data
busy  output  1  operation in progress; core must stall mfhi/mflo/new muldiv
done  output  1  one-cycle pulse, hi/lo hold new result this cycle
hi  output  WIDTH  HI register (remainder / product upper half)
lo  output  WIDTH  LO register (quotient / product lower half)

Behaviour:
- Reset is asynchronous, active-high, and can be asserted at any time including mid-operation. It forces state IDLE, busy=0, done=0, hi=0, lo=0, and clears the counter and working registers.
- State machine IDLE -> CALC -> FINISH -> IDLE. busy=1 in CALC and FINISH; busy=0 otherwise.
- IDLE: on an edge E0 with start=1, the block latches op and a, b. It also latches operand signs for signed ops, plus magnitudes |a| and |b| (two's-complement negate if MSB=1 and op signed). Counter <= 0, next state CALC.
- CALC, edges E1..E32: one shift-add (multiply) or restoring shift-subtract (divide) step per edge on magnitudes. The counter increments, and at counter=WIDTH-1 the next state is FINISH.
- FINISH, edge E33: sign fixup applied, hi/lo written, done=1 for the following cycle only, next state IDLE. The result is therefore visible WIDTH+1 edges after the start edge.
- Multiply: 2*WIDTH unsigned product of magnitudes. For mult, negate the full 2*WIDTH value if sign(a)!=sign(b). Then hi=product[63:32], lo=product[31:0].
- Divide: unsigned quotient Q and remainder R of the magnitudes. For div, negate Q if sign(a)!=sign(b), and negate R if sign(a)=1. Then lo=Q, hi=R.
- Signed overflow case 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This falls out naturally from the magnitude path.
- Divide by zero (b=0, div or divu) takes the same latency. Result is lo=0xFFFFFFFF and hi=a (raw dividend), with no sign fixup applied.
- start while busy=1 is ignored; there is no queueing, and latched operands are not disturbed.
- wr_hi/wr_lo act in IDLE only, taking effect at the next edge. They are ignored while busy=1. In IDLE, start=1 has priority: same-edge wr_hi/wr_lo are dropped. wr_hi and wr_lo together write both registers.
- hi/lo hold their value between operations and during CALC. They change only in FINISH, on mthi/mtlo, or on reset.
- done and start can coincide: a new start on the cycle done=1 is accepted because busy=0.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF -> busy high for edges E0..E33; done pulses exactly 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001.
- mult a=0xFFFFFFFD(-3) b=0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- div a=0xFFFFFFF9(-7) b=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Second check: div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu a=0x0000000A b=0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x0000000A, done pulses once.
- Start multu 3*4, pulse start (op=divu) and wr_hi (wd=0x55) at cycle 5 -> both ignored; result hi=0, lo=0x0000000C. Then in IDLE, wr_hi with wd=0x55 -> hi=0x00000055 next cycle, lo unchanged.
- Start mult, assert reset asynchronously mid-cycle at cycle 10 -> busy, done, hi, lo go 0 immediately without waiting for a clock edge. After release, a new multu 2*3 completes normally with lo=6.
